// File: rtl/int_regfile_sb.sv
// int_regfile_sb
// Integer register file for the RISC-V core. It has NRD combinational read ports
// and two write ports, and it forwards writes to reads in the same cycle.
// A scoreboard tracks registers that are waiting for a long-latency write, so
// decode can stall on RAW and WAW hazards.
//
// Ports
//   clk_in, reset_in        clock (rising edge) and asynchronous active-high reset
//   rs_addr_in / rs_data_out / rs_busy_out
//                           read port i uses slice [i*AW +: AW] / [i*XLEN +: XLEN] / bit i
//   wr0_en_in/addr/data     WB0: in-order pipeline writeback
//   wr1_en_in/addr/data     WB1: long-latency return; also retires the busy entry
//   issue_en_in, issue_rd_in
//                           long-latency issue; marks its destination busy
//   busy_cnt_out            registered popcount of the busy bits
//   err_out                 sticky scoreboard protocol error
module int_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_busy_out,
    input  logic                wr0_en_in,
    input  logic [AW-1:0]       wr0_addr_in,
    input  logic [XLEN-1:0]     wr0_data_in,
    input  logic                wr1_en_in,
    input  logic [AW-1:0]       wr1_addr_in,
    input  logic [XLEN-1:0]     wr1_data_in,
    input  logic                issue_en_in,
    input  logic [AW-1:0]       issue_rd_in,
    output logic [AW:0]         busy_cnt_out,
    output logic                err_out
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [AW:0]      busy_cnt_q;
    logic             err_q;

    logic wr0_vld;
    logic wr1_vld;
    logic set_vld;
    logic cnt_inc;
    logic cnt_dec;
    logic err_set;

    // Register 0 swallows writes and issues when it is hard-wired.
    assign wr0_vld = wr0_en_in   && !(ZERO_REG != 0 && wr0_addr_in == '0);
    assign wr1_vld = wr1_en_in   && !(ZERO_REG != 0 && wr1_addr_in == '0);
    assign set_vld = issue_en_in && !(ZERO_REG != 0 && issue_rd_in == '0);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_vld)   set_vec[issue_rd_in] = 1'b1;
        if (wr1_en_in) clr_vec[wr1_addr_in] = 1'b1;
        // Set is applied after clear so a back-to-back reissue keeps the bit.
        busy_d  = (busy_q & ~clr_vec) | set_vec;
    end

    // Only the issue and WB1 bits can change, so the count moves by at most one
    // in each direction and can be tracked incrementally.
    always_comb begin
        cnt_inc = set_vld && !busy_q[issue_rd_in];
        cnt_dec = wr1_en_in && busy_q[wr1_addr_in]
                  && !(set_vld && issue_rd_in == wr1_addr_in);
        err_set = (set_vld && busy_q[issue_rd_in]
                   && !(wr1_en_in && wr1_addr_in == issue_rd_in))
                  || (wr1_en_in && !busy_q[wr1_addr_in]
                      && !(set_vld && issue_rd_in == wr1_addr_in))
                  || (wr0_en_in && busy_q[wr0_addr_in]);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // WB1 has priority over WB0 on the same address.
            for (int r = 0; r < NREGS; r++) begin
                if (wr1_vld && wr1_addr_in == AW'(r))
                    regs_q[r] <= wr1_data_in;
                else if (wr0_vld && wr0_addr_in == AW'(r))
                    regs_q[r] <= wr0_data_in;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
            if (err_set) err_q <= 1'b1;
        end
    end

    assign busy_cnt_out = busy_cnt_q;
    assign err_out      = err_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs_addr_in[i*AW +: AW];

        always_comb begin
            if (ZERO_REG != 0 && addr == '0)
                data = '0;
            else if (wr1_en_in && wr1_addr_in == addr)
                data = wr1_data_in;
            else if (wr0_en_in && wr0_addr_in == addr)
                data = wr0_data_in;
            else
                data = regs_q[addr];
        end

        assign rs_data_out[i*XLEN +: XLEN] = data;
        // A returning WB1 releases its consumer now, since its data is forwarded.
        assign rs_busy_out[i] = busy_q[addr] & ~(wr1_en_in && wr1_addr_in == addr);
    end

endmodule
